// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (also used by the RX path),
// oversampling constants and the parity fold helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Folds one more data bit into a running parity accumulator.
    function automatic logic parity_fold(input logic acc, input logic data_bit);
        return acc ^ data_bit;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timer for the UART transmitter: counts baud_x16_en strobes and pulses
// bit_done on the strobe that completes a 16-tick bit. clr has priority over
// tick, so a strobe coinciding with clr is not counted.
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic bit_done
);

    localparam logic [TICK_CNT_W-1:0] LAST_TICK = TICK_CNT_W'(OVERSAMPLE - 1);

    logic [TICK_CNT_W-1:0] cnt_q;
    logic [TICK_CNT_W-1:0] cnt_d;

    // Next tick count: clear on accept, otherwise advance (and wrap) per strobe.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + TICK_CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = tick && !clr && (cnt_q == LAST_TICK);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, STOP_BITS stop bits, paced by the 16x baud strobe.
// Optional feature: define UART_TX_PARITY_EN to compile in the parity bit;
// PARITY_ODD then selects odd (1) or even (0) parity.
// All outputs come straight from flops; next-cycle values are derived from
// the next FSM state so tx changes on the same edge as the state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_x16_en,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP_IDX = 4'(STOP_BITS - 1);

    uart_state_e           state_q;
    uart_state_e           state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [3:0]            bit_idx_q;
    logic [3:0]            bit_idx_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  tx_ready_q;
    logic                  tx_ready_d;
    logic                  tx_busy_q;
    logic                  tx_busy_d;
    logic                  accept_s;
    logic                  bit_done_s;
`ifdef UART_TX_PARITY_EN
    logic                  par_q;
    logic                  par_d;
`else
    logic                  unused_parity_odd_s;
    assign unused_parity_odd_s = 1'(PARITY_ODD);
`endif

    assign accept_s = tx_valid && tx_ready_q;

    uart_tx_bit_timer u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept_s),
        .tick     (baud_x16_en),
        .bit_done (bit_done_s)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= 4'd0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, data shifting and parity folding.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    bit_idx_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                    par_d     = 1'(PARITY_ODD);
`endif
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
`ifdef UART_TX_PARITY_EN
                    par_d   = parity_fold(par_q, shift_q[0]);
`endif
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        bit_idx_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_d   = ST_STOP;
                    bit_idx_d = 4'd0;
                end else begin
                    state_d   = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = 4'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so the output flops track the FSM.
    always_comb begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b0;
        tx_busy_d  = 1'b1;
        case (state_d)
            ST_IDLE: begin
                tx_d       = 1'b1;
                tx_ready_d = 1'b1;
                tx_busy_d  = 1'b0;
            end
            ST_START: begin
                tx_d = 1'b0;
            end
            ST_DATA: begin
                tx_d = shift_d[0];
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = par_d;
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
            end
            default: begin
                tx_d       = 1'b1;
                tx_ready_d = 1'b0;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Frames on the main instance are decoded
// by a monitor and compared against a scoreboard queue filled at accept.
// Extra instances cover two stop bits and odd parity.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int NB       = 1 + DW + PBITS + 1;
    localparam int BIT_CLKS = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    bc = 2'd0;
    logic          baud;
    logic          tx_valid, tx_ready, tx, tx_busy;
    logic [DW-1:0] tx_data;
    logic          tx_valid2, tx_ready2, tx2, tx_busy2;
    logic [DW-1:0] tx_data2;
    logic          tx_valid3, tx_ready3, tx3, tx_busy3;
    logic [DW-1:0] tx_data3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] wire_bits;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] mid_data;
        logic [9:0] wire_bits;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bc <= bc + 2'd1;
    assign baud = (bc == 2'd3);

    uart_tx #(.DATA_WIDTH(DW), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .baud_x16_en(baud), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy)
    );

    uart_tx #(.DATA_WIDTH(DW), .STOP_BITS(2), .PARITY_ODD(0)) dut_stop2 (
        .clk(clk), .rst_n(rst_n), .baud_x16_en(baud), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2)
    );

    uart_tx #(.DATA_WIDTH(DW), .STOP_BITS(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .baud_x16_en(baud), .tx_data(tx_data3),
        .tx_valid(tx_valid3), .tx_ready(tx_ready3), .tx(tx3), .tx_busy(tx_busy3)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    function automatic logic line_of(input int w);
        case (w)
            0:       return tx;
            1:       return tx2;
            default: return tx3;
        endcase
    endfunction

    function automatic logic ready_of(input int w);
        case (w)
            0:       return tx_ready;
            1:       return tx_ready2;
            default: return tx_ready3;
        endcase
    endfunction

    // Waits (bounded) at falling edges until the instance reports ready.
    task automatic wait_ready(input int w, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (ready_of(w) !== 1'b1 && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (ready_of(w) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: tx_ready still low after %0d cycles, expected high", name, budget);
        end
    endtask

    task automatic wait_sb_empty(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            n++;
            @(negedge clk);
        end
        check("sb_drain_wait", 32'(sb_q.size()), 32'd0);
    endtask

    // Samples each bit near its middle; call on the cycle the start bit begins.
    task automatic decode(input int w, input int nb, output logic [15:0] bits);
        bits = '0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        bits[0] = line_of(w);
        for (int k = 1; k < nb; k++) begin
            repeat (BIT_CLKS) @(negedge clk);
            bits[k] = line_of(w);
        end
    endtask

    // Drives one byte into the main instance and optionally records the expected frame.
    task automatic send_main(input logic [7:0] d, input logic [9:0] wire_bits,
                             input bit push, input bit hold, output int acc_cyc);
        exp_t e;
        wait_ready(0, 2000, "send_wait_ready");
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        check("accept_outputs", {29'd0, tx, tx_ready, tx_busy}, 32'b001);
        if (push) begin
            e.data      = d;
            e.wire_bits = wire_bits;
            sb_q.push_back(e);
        end
        if (!hold) tx_valid = 1'b0;
    endtask

    // Frame monitor for the main instance: decode and compare against the scoreboard.
    initial begin : monitor
        logic        prev;
        logic [15:0] got;
        exp_t        e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
                decode(0, NB, got);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_frame: got frame 0x%0h, expected none", got);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_start_data", {23'd0, got[8:0]}, {23'd0, e.wire_bits[8:0]});
`ifdef UART_TX_PARITY_EN
                    check("sb_parity", {31'd0, got[9]}, {31'd0, ^e.data});
`endif
                    check("sb_stop", {31'd0, got[NB-1]}, {31'd0, e.wire_bits[9]});
                end
            end
            prev = tx;
        end
    end

    initial begin : main
        int          acc;
        int          n;
        int          lo_run;
        int          hi_run;
        int          r;
        int          a;
        bit          bad;
        logic [15:0] got;

        tx_valid  = 1'b0; tx_data  = '0;
        tx_valid2 = 1'b0; tx_data2 = '0;
        tx_valid3 = 1'b0; tx_data3 = '0;
        rst_n     = 1'b0;

        vecs[0] = '{8'hA5, 8'h5A, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 8'hFF, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 8'h00, 10'b1_11111111_0};
        vecs[3] = '{8'h01, 8'h80, 10'b1_00000001_0};
        vecs[4] = '{8'h80, 8'h3C, 10'b1_10000000_0};
        vecs[5] = '{8'h07, 8'hF0, 10'b1_00000111_0};

        // Reset values and long idle after release
        repeat (10) @(negedge clk);
        bad = (tx !== 1'b1) || (tx_ready !== 1'b1) || (tx_busy !== 1'b0) ||
              (tx2 !== 1'b1) || (tx3 !== 1'b1);
        check("reset_values", {31'd0, bad}, 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 ||
                tx2 !== 1'b1 || tx_ready2 !== 1'b1 || tx3 !== 1'b1) bad = 1'b1;
        end
        check("idle_after_reset", {31'd0, bad}, 32'd0);
        mon_en = 1'b1;

        // Single frame 0xA5 with timing measurements
        send_main(8'hA5, 10'b1_10100101_0, 1'b1, 1'b0, acc);
        lo_run = 0;
        @(negedge clk);
        while (tx === 1'b0 && lo_run < 100) begin
            lo_run++;
            @(negedge clk);
        end
        check_range("start_bit_len", lo_run, 61, 64);
        hi_run = 0;
        while (tx === 1'b1 && hi_run < 100) begin
            hi_run++;
            @(negedge clk);
        end
        check("data_bit0_len", 32'(hi_run), 32'd64);
        n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        r = cyc;
        check_range("ready_return", r - acc, BIT_CLKS * NB - 3, BIT_CLKS * NB + 3);
        wait_sb_empty(200);

        // Table-driven frames with ignored mid-frame data/valid changes
        for (int i = 0; i < 6; i++) begin
            send_main(vecs[i].data, vecs[i].wire_bits, 1'b1, 1'b0, acc);
            repeat (200) @(negedge clk);
            tx_data  = vecs[i].mid_data;
            tx_valid = 1'b1;
            check("busy_mid_frame", {31'd0, tx_busy}, 32'd1);
            repeat (20) @(negedge clk);
            tx_valid = 1'b0;
            wait_ready(0, 1000, "vec_frame_end");
        end
        wait_sb_empty(200);

        // Back-to-back frames with tx_valid held high
        send_main(8'h55, 10'b1_01010101_0, 1'b1, 1'b1, acc);
        tx_data = 8'hAA;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tx_ready !== 1'b1 && n < 2000);
        r = cyc;
        check("b2b_idle_high", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        a = cyc;
        check("b2b_accept_gap", 32'(a - r), 32'd1);
        check("b2b_second_start", {30'd0, tx, tx_ready}, 32'b00);
        sb_q.push_back('{8'hAA, 10'b1_10101010_0});
        tx_valid = 1'b0;
        wait_ready(0, 1000, "b2b_frame_end");
        wait_sb_empty(200);

        // Two stop bits: stop period measured from rise to ready
        @(negedge clk);
        tx_valid2 = 1'b1;
        tx_data2  = 8'h00;
        @(posedge clk);
        #1;
        tx_valid2 = 1'b0;
        check("stop2_start_low", {31'd0, tx2}, 32'd0);
        n = 0;
        @(negedge clk);
        while (tx2 !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        r = cyc;
        n = 0;
        while (tx_ready2 !== 1'b1 && n < 1000) begin
            if (tx2 !== 1'b1) n = 1000;
            n++;
            @(negedge clk);
        end
        a = cyc;
        check("stop2_high_len", 32'(a - r), 32'd128);

`ifdef UART_TX_PARITY_EN
        // Odd parity instance: 0x07 has three ones, so the parity bit is 0
        @(negedge clk);
        tx_valid3 = 1'b1;
        tx_data3  = 8'h07;
        @(posedge clk);
        #1;
        tx_valid3 = 1'b0;
        decode(2, NB, got);
        check("odd_frame_data", {23'd0, got[8:0]}, {23'd0, 9'b00000111_0});
        check("odd_parity_bit", {31'd0, got[9]}, 32'd0);
        check("odd_stop_bit", {31'd0, got[10]}, 32'd1);
        wait_ready(2, 1000, "odd_frame_end");
`else
        got = '0;
`endif

        // Reset during data bit 3 aborts the frame
        wait_sb_empty(1000);
        mon_en = 1'b0;
        send_main(8'hA5, 10'b1_10100101_0, 1'b0, 1'b0, acc);
        repeat (288) @(negedge clk);
        check("pre_reset_bit3_low", {31'd0, tx}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {29'd0, tx, tx_ready, tx_busy}, 32'b110);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("post_reset_idle", {31'd0, bad}, 32'd0);
        mon_en = 1'b1;

        // Normal operation resumes after reset
        send_main(8'h3C, 10'b1_00111100_0, 1'b1, 1'b0, acc);
        wait_ready(0, 1000, "post_reset_frame_end");
        wait_sb_empty(200);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
